// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel A2D converter. Each 16-bit frame carries a command.
// The response to a frame is the conversion of the channel named by the previous valid command.
module a2d_spi_resp #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned RESET_CHAN = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  input  logic [8*DATA_W-1:0] ch_data,
  output logic [15:0]         cmd_rcvd,
  output logic                cmd_vld,
  output logic [2:0]          chan,
  output logic                frame_err
);

  localparam logic [4:0] FrameBits = 5'd16;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ss_sync_q, sclk_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [2:0]  chan_q, chan_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic        miso_q, miso_d;

  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [DATA_W-1:0] ch_arr [8];
  logic [15:0] tx_load;

  for (genvar g = 0; g < 8; g++) begin : g_ch
    assign ch_arr[g] = ch_data[g*DATA_W +: DATA_W];
  end

  assign tx_load = 16'(ch_arr[chan_q]);

  // SS_n sync resets low so a frame already in progress at reset release never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= 3'b000;
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], SS_n};
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
    end
  end

  assign ss_fall   = ~ss_sync_q[1] &  ss_sync_q[2];
  assign ss_rise   =  ss_sync_q[1] & ~ss_sync_q[2];
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    chan_d  = chan_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    pend_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ss_fall || pend_q) begin
          state_d = StShift;
          tx_d    = tx_load;
          rx_d    = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (sclk_rise && (cnt_q < FrameBits)) begin
          rx_d  = {rx_q[14:0], mosi_sync_q[1]};
          cnt_d = cnt_q + 5'd1;
        end
        // Falls before the first rise are ignored so either SCLK idle level works.
        if (sclk_fall && (cnt_q != 5'd0) && (cnt_q < FrameBits)) begin
          tx_d = {tx_q[14:0], 1'b0};
        end
        if (ss_rise) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (cnt_q == FrameBits) begin
          cmd_d  = rx_q;
          chan_d = rx_q[13:11];
          vld_d  = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
        pend_d  = ss_fall;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    miso_d = ((state_d == StShift) && (cnt_d < FrameBits)) ? tx_d[15] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      chan_q  <= 3'(RESET_CHAN);
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      chan_q  <= chan_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      miso_q  <= miso_d;
    end
  end

  assign MISO      = miso_q;
  assign cmd_rcvd  = cmd_q;
  assign cmd_vld   = vld_q;
  assign chan      = chan_q;
  assign frame_err = err_q;

endmodule
